board_turn_controller: RTL and testbench

//  Sequences one player turn on the Buscaminas board: moves a cursor, reveals or flags a cell

---
 rtl/board_turn_controller_if.sv | 42 ++++
 rtl/board_turn_controller.sv | 158 +++++++++++++++
 tb/tb_board_turn_controller.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/board_turn_controller_if.sv
// Bus between the board turn controller and its surroundings (game FSM, buttons, cell RAM).
// The slave modport is the controller's view; the master modport drives it.
interface board_turn_controller_if #(
    parameter int AW = 6
);
    logic          i_play;
    logic          i_start;
    logic [3:0]    i_mines;
    logic          i_btnUp;
    logic          i_btnDown;
    logic          i_btnLeft;
    logic          i_btnRight;
    logic          i_btnSel;
    logic          i_btnFlag;
    logic [AW-1:0] o_rdAddr;
    logic [6:0]    i_rdData;
    logic          o_wrEn;
    logic [AW-1:0] o_wrAddr;
    logic [6:0]    o_wrData;
    logic [3:0]    o_curRow;
    logic [3:0]    o_curCol;
    logic [7:0]    o_revealed;
    logic          o_busy;
    logic          o_win;
    logic          o_lose;

    modport slave (
        input  i_play, i_start, i_mines,
        input  i_btnUp, i_btnDown, i_btnLeft, i_btnRight, i_btnSel, i_btnFlag,
        input  i_rdData,
        output o_rdAddr, o_wrEn, o_wrAddr, o_wrData,
        output o_curRow, o_curCol, o_revealed, o_busy, o_win, o_lose
    );

    modport master (
        output i_play, i_start, i_mines,
        output i_btnUp, i_btnDown, i_btnLeft, i_btnRight, i_btnSel, i_btnFlag,
        output i_rdData,
        input  o_rdAddr, o_wrEn, o_wrAddr, o_wrData,
        input  o_curRow, o_curCol, o_revealed, o_busy, o_win, o_lose
    );
endinterface

// File: rtl/board_turn_controller.sv
// One Buscaminas player turn: cursor moves plus reveal/flag read-modify-write on the cell RAM.
// Define TURN_CTRL_FLAG_EN to enable flag toggling and make flagged cells refuse reveal.
module board_turn_controller #(
    parameter int ROWS = 8,
    parameter int COLS = 8,
    parameter int AW   = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    board_turn_controller_if.slave bus
);

    localparam logic [2:0] S_WAIT  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_CHECK = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_END   = 3'd4;

    localparam int         CELLS   = ROWS * COLS;
    localparam logic [3:0] ROW_MAX = 4'(ROWS - 1);
    localparam logic [3:0] COL_MAX = 4'(COLS - 1);

`ifdef TURN_CTRL_FLAG_EN
    localparam bit FLAG_ON = 1'b1;
`else
    localparam bit FLAG_ON = 1'b0;
`endif

    logic [2:0]    r_state;
    logic [3:0]    r_row;
    logic [3:0]    r_col;
    logic [7:0]    r_revealed;
    logic          r_win;
    logic          r_lose;
    logic          r_opFlag;
    logic          r_wrEn;
    logic [AW-1:0] r_rdAddr;
    logic [AW-1:0] r_wrAddr;
    logic [6:0]    r_wrData;

    logic          w_accept;
    logic          w_flagCmd;
    logic [AW-1:0] w_curAddr;
    logic [8:0]    w_target;
    logic [8:0]    w_nextCount;
    logic          w_winReach;

    assign w_accept  = (r_state == S_WAIT) && bus.i_play && (bus.i_mines != 4'd0)
                       && !r_win && !r_lose;
    assign w_flagCmd = FLAG_ON && bus.i_btnFlag && !bus.i_btnSel;
    assign w_curAddr = AW'(int'(r_row) * COLS + int'(r_col));

    // Nine bits so a 16x16 board still compares correctly; too many mines can never win.
    assign w_target    = 9'(CELLS) - {5'd0, bus.i_mines};
    assign w_nextCount = {1'b0, r_revealed} + 9'd1;
    assign w_winReach  = ({5'd0, bus.i_mines} < 9'(CELLS)) && (w_nextCount == w_target);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_WAIT;
            r_row      <= 4'd0;
            r_col      <= 4'd0;
            r_revealed <= 8'd0;
            r_win      <= 1'b0;
            r_lose     <= 1'b0;
            r_opFlag   <= 1'b0;
            r_wrEn     <= 1'b0;
            r_rdAddr   <= '0;
            r_wrAddr   <= '0;
            r_wrData   <= 7'd0;
        end else if (bus.i_start) begin
            r_state    <= S_WAIT;
            r_row      <= 4'd0;
            r_col      <= 4'd0;
            r_revealed <= 8'd0;
            r_win      <= 1'b0;
            r_lose     <= 1'b0;
            r_opFlag   <= 1'b0;
            r_wrEn     <= 1'b0;
            r_rdAddr   <= '0;
            r_wrAddr   <= '0;
            r_wrData   <= 7'd0;
        end else begin
            r_wrEn <= 1'b0;
            case (r_state)
                S_WAIT: begin
                    if (w_accept) begin
                        if (bus.i_btnSel || w_flagCmd) begin
                            r_opFlag <= w_flagCmd;
                            r_rdAddr <= w_curAddr;
                            r_state  <= S_READ;
                        end else if (bus.i_btnUp) begin
                            r_row <= (r_row == 4'd0) ? ROW_MAX : r_row - 4'd1;
                        end else if (bus.i_btnDown) begin
                            r_row <= (r_row == ROW_MAX) ? 4'd0 : r_row + 4'd1;
                        end else if (bus.i_btnLeft) begin
                            r_col <= (r_col == 4'd0) ? COL_MAX : r_col - 4'd1;
                        end else if (bus.i_btnRight) begin
                            r_col <= (r_col == COL_MAX) ? 4'd0 : r_col + 4'd1;
                        end
                    end
                end
                S_READ: begin
                    r_state <= S_CHECK;
                end
                // Cell word is valid here; decide whether the turn writes back.
                S_CHECK: begin
                    if (r_opFlag) begin
                        if (bus.i_rdData[5]) begin
                            r_state <= S_WAIT;
                        end else begin
                            r_wrEn   <= 1'b1;
                            r_wrAddr <= r_rdAddr;
                            r_wrData <= bus.i_rdData ^ 7'b0010000;
                            r_state  <= S_WRITE;
                        end
                    end else if (bus.i_rdData[5] || (FLAG_ON && bus.i_rdData[4])) begin
                        r_state <= S_WAIT;
                    end else begin
                        r_wrEn   <= 1'b1;
                        r_wrAddr <= r_rdAddr;
                        r_wrData <= bus.i_rdData | 7'b0100000;
                        r_state  <= S_WRITE;
                        if (bus.i_rdData[6]) begin
                            r_lose <= 1'b1;
                        end else begin
                            r_revealed <= r_revealed + 8'd1;
                            if (w_winReach) begin
                                r_win <= 1'b1;
                            end
                        end
                    end
                end
                S_WRITE: begin
                    r_state <= (r_win || r_lose) ? S_END : S_WAIT;
                end
                S_END: begin
                    r_state <= S_END;
                end
                default: begin
                    r_state <= S_WAIT;
                end
            endcase
        end
    end

    assign bus.o_rdAddr   = r_rdAddr;
    assign bus.o_wrEn     = r_wrEn;
    assign bus.o_wrAddr   = r_wrAddr;
    assign bus.o_wrData   = r_wrData;
    assign bus.o_curRow   = r_row;
    assign bus.o_curCol   = r_col;
    assign bus.o_revealed = r_revealed;
    assign bus.o_busy     = (r_state != S_WAIT);
    assign bus.o_win      = r_win;
    assign bus.o_lose     = r_lose;

endmodule

// File: tb/tb_board_turn_controller.sv
// Scoreboard bench for board_turn_controller on an 8x8 board with a behavioural cell RAM.
// Expected writes are queued at stimulus time and checked by an independent write monitor.
module tb_board_turn_controller;

    localparam int ROWS = 8;
    localparam int COLS = 8;
    localparam int AW   = 6;

    localparam logic [5:0] B_NONE  = 6'b000000;
    localparam logic [5:0] B_SEL   = 6'b100000;
    localparam logic [5:0] B_FLAG  = 6'b010000;
    localparam logic [5:0] B_UP    = 6'b001000;
    localparam logic [5:0] B_DOWN  = 6'b000100;
    localparam logic [5:0] B_LEFT  = 6'b000010;
    localparam logic [5:0] B_RIGHT = 6'b000001;

    typedef struct {
        logic [AW-1:0] addr;
        logic [6:0]    data;
        int            cyc;
    } wr_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   expRev = 0;
    wr_t  expQ[$];
    wr_t  monExp;
    logic [6:0] mem [0:63];

    always #5 clk = ~clk;

    board_turn_controller_if #(.AW(AW)) bus ();

    board_turn_controller #(.ROWS(ROWS), .COLS(COLS), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Cell RAM: one-cycle registered read, synchronous write.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        bus.i_rdData <= mem[bus.o_rdAddr];
        if (bus.o_wrEn === 1'b1) begin
            mem[bus.o_wrAddr] <= bus.o_wrData;
        end
    end

    // Every write strobe must match the oldest expected write, including its cycle.
    always @(negedge clk) begin
        if (bus.o_wrEn === 1'b1) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_write: got addr %0d data %h at cycle %0d, expected no write",
                         bus.o_wrAddr, bus.o_wrData, cyc);
            end else begin
                monExp = expQ.pop_front();
                if (bus.o_wrAddr !== monExp.addr || bus.o_wrData !== monExp.data || cyc != monExp.cyc) begin
                    errors++;
                    $display("[TB] FAIL write: got addr %0d data %h cycle %0d, expected addr %0d data %h cycle %0d",
                             bus.o_wrAddr, bus.o_wrData, cyc, monExp.addr, monExp.data, monExp.cyc);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic setButtons(input logic [5:0] btn);
        {bus.i_btnSel, bus.i_btnFlag, bus.i_btnUp, bus.i_btnDown, bus.i_btnLeft, bus.i_btnRight} = btn;
    endtask

    task automatic applyStimulus(input logic [5:0] btn, input bit expWr, input int addr, input logic [6:0] data);
        @(posedge clk);
        #1;
        setButtons(btn);
        if (expWr) begin
            expQ.push_back('{AW'(addr), data, cyc + 3});
        end
        @(posedge clk);
        #1;
        setButtons(B_NONE);
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        bus.i_play  = 1'b0;
        bus.i_start = 1'b0;
        bus.i_mines = 4'd0;
        setButtons(B_NONE);
        for (int i = 0; i < 64; i++) mem[i] = 7'h00;
        mem[0]  = 7'h01;
        mem[19] = 7'h40;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_row", bus.o_curRow, 0);
        checkOutput("reset_col", bus.o_curCol, 0);
        checkOutput("reset_revealed", bus.o_revealed, 0);
        checkOutput("reset_win", bus.o_win, 0);
        checkOutput("reset_lose", bus.o_lose, 0);
        checkOutput("reset_busy", bus.o_busy, 0);
        checkOutput("reset_wren", bus.o_wrEn, 0);
        checkOutput("reset_wraddr", bus.o_wrAddr, 0);
        checkOutput("reset_wrdata", bus.o_wrData, 0);
        rst_n = 1'b1;
        bus.i_mines = 4'd1;

        applyStimulus(B_LEFT, 0, 0, 7'h00);
        checkOutput("play_low_blocks_move", bus.o_curCol, 0);
        bus.i_play = 1'b1;

        applyStimulus(B_LEFT, 0, 0, 7'h00);
        checkOutput("left_wrap_col", bus.o_curCol, 7);
        checkOutput("left_wrap_row", bus.o_curRow, 0);
        checkOutput("move_busy", bus.o_busy, 0);
        applyStimulus(B_RIGHT, 0, 0, 7'h00);
        checkOutput("right_wrap_col", bus.o_curCol, 0);
        applyStimulus(B_UP, 0, 0, 7'h00);
        checkOutput("up_wrap_row", bus.o_curRow, 7);
        applyStimulus(B_DOWN, 0, 0, 7'h00);
        checkOutput("down_wrap_row", bus.o_curRow, 0);
        applyStimulus(B_DOWN | B_LEFT, 0, 0, 7'h00);
        checkOutput("prio_down_row", bus.o_curRow, 1);
        checkOutput("prio_left_dropped", bus.o_curCol, 0);
        applyStimulus(B_UP, 0, 0, 7'h00);

        applyStimulus(B_SEL, 1, 0, 7'h21);
        expRev = 1;
        checkOutput("reveal0_count", bus.o_revealed, expRev);
        checkOutput("reveal0_win", bus.o_win, 0);
        checkOutput("reveal0_busy", bus.o_busy, 0);

        applyStimulus(B_SEL | B_UP, 0, 0, 7'h00);
        checkOutput("sel_up_row", bus.o_curRow, 0);
        checkOutput("rereveal_count", bus.o_revealed, expRev);

`ifdef TURN_CTRL_FLAG_EN
        applyStimulus(B_RIGHT, 0, 0, 7'h00);
        applyStimulus(B_FLAG, 1, 1, 7'h10);
        applyStimulus(B_SEL, 0, 0, 7'h00);
        checkOutput("flagged_refuse_count", bus.o_revealed, expRev);
        applyStimulus(B_FLAG, 1, 1, 7'h00);
`else
        mem[1] = 7'h10;
        applyStimulus(B_RIGHT, 0, 0, 7'h00);
        applyStimulus(B_FLAG, 0, 0, 7'h00);
        checkOutput("flag_ignored_col", bus.o_curCol, 1);
        applyStimulus(B_SEL, 1, 1, 7'h30);
        expRev = 2;
        checkOutput("flagged_reveal_count", bus.o_revealed, expRev);
`endif

        // play drops right after the sel: turn still writes, then commands blocked.
        applyStimulus(B_RIGHT, 0, 0, 7'h00);
        @(posedge clk);
        #1;
        bus.i_btnSel = 1'b1;
        expQ.push_back('{AW'(2), 7'h20, cyc + 3});
        @(posedge clk);
        #1;
        bus.i_btnSel = 1'b0;
        bus.i_play   = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        expRev++;
        checkOutput("play_fall_count", bus.o_revealed, expRev);
        applyStimulus(B_RIGHT, 0, 0, 7'h00);
        checkOutput("play_fall_blocks", bus.o_curCol, 2);
        bus.i_play = 1'b1;

        // Reset while the read is in flight aborts the turn with no write.
        applyStimulus(B_RIGHT, 0, 0, 7'h00);
        @(posedge clk);
        #1;
        bus.i_btnSel = 1'b1;
        @(posedge clk);
        #1;
        bus.i_btnSel = 1'b0;
        checkOutput("busy_in_read", bus.o_busy, 1);
        rst_n = 1'b0;
        #2;
        checkOutput("abort_busy", bus.o_busy, 0);
        checkOutput("abort_col", bus.o_curCol, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("abort_revealed", bus.o_revealed, 0);

        // Mine at (2,3) = address 19.
        applyStimulus(B_DOWN, 0, 0, 7'h00);
        applyStimulus(B_DOWN, 0, 0, 7'h00);
        for (int i = 0; i < 3; i++) applyStimulus(B_RIGHT, 0, 0, 7'h00);
        applyStimulus(B_SEL, 1, 19, 7'h60);
        checkOutput("mine_lose", bus.o_lose, 1);
        checkOutput("mine_win", bus.o_win, 0);
        checkOutput("mine_count", bus.o_revealed, 0);
        applyStimulus(B_SEL, 0, 0, 7'h00);
        checkOutput("after_lose_lose", bus.o_lose, 1);
        applyStimulus(B_LEFT, 0, 0, 7'h00);
        checkOutput("after_lose_col", bus.o_curCol, 3);

        // start overrides a same-cycle move.
        @(posedge clk);
        #1;
        bus.i_start   = 1'b1;
        bus.i_btnLeft = 1'b1;
        @(posedge clk);
        #1;
        bus.i_start   = 1'b0;
        bus.i_btnLeft = 1'b0;
        checkOutput("start_lose", bus.o_lose, 0);
        checkOutput("start_row", bus.o_curRow, 0);
        checkOutput("start_col", bus.o_curCol, 0);
        checkOutput("start_busy", bus.o_busy, 0);

        bus.i_mines = 4'd0;
        applyStimulus(B_LEFT, 0, 0, 7'h00);
        checkOutput("zero_mines_blocks", bus.o_curCol, 0);

        // 15 mines: 49 safe cells at addresses 0..48.
        bus.i_mines = 4'd15;
        for (int i = 0; i < 64; i++) mem[i] = (i < 49) ? 7'h00 : 7'h40;
        for (int i = 0; i < 49; i++) begin
            applyStimulus(B_SEL, 1, i, 7'h20);
            if (i == 47) begin
                checkOutput("win_not_early", bus.o_win, 0);
            end
            if (i < 48) begin
                if (i % 8 == 7) begin
                    applyStimulus(B_RIGHT, 0, 0, 7'h00);
                    applyStimulus(B_DOWN, 0, 0, 7'h00);
                end else begin
                    applyStimulus(B_RIGHT, 0, 0, 7'h00);
                end
            end
        end
        checkOutput("win_set", bus.o_win, 1);
        checkOutput("win_count", bus.o_revealed, 49);
        checkOutput("win_no_lose", bus.o_lose, 0);
        applyStimulus(B_SEL, 0, 0, 7'h00);
        checkOutput("after_win_count", bus.o_revealed, 49);
        applyStimulus(B_RIGHT, 0, 0, 7'h00);
        checkOutput("after_win_row", bus.o_curRow, 6);
        checkOutput("after_win_col", bus.o_curCol, 0);

        repeat (2) @(posedge clk);
        #1;
        checkOutput("pending_writes", expQ.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
